// File: rtl/axi4l_decoder_if.sv
// ============================================================================
// Module   : axi4l_if
// Brief    : AXI4-Lite bus bundle with master and slave modports.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axi4l_if (
  input wire logic aclk,
  input wire logic aresetn
);
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

`default_nettype wire

// File: rtl/axi4l_decoder.sv
// ============================================================================
// Module   : axi4l_decoder
// Brief    : AXI4-Lite 1-to-N decoder, 4 KiB windows, DECERR for unmapped.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi4l_decoder #(
  parameter int          N        = 4,
  parameter logic [31:0] BASE [N] = '{32'h4000_0000, 32'h4000_1000,
                                      32'h4000_2000, 32'h4000_3000}
) (
  input wire logic  aclk,
  input wire logic  aresetn,
  axi4l_if.slave    s,
  axi4l_if.master   m [N]
);

  localparam int         SW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] c_RESP_DEC = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_ERR, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP}        rstate_t;

  wstate_t       r_wstate;
  logic [31:0]   r_awaddr;
  logic [2:0]    r_awprot;
  logic [SW-1:0] r_wsel;
  logic          r_werr;
  logic          r_aw_done;
  logic          r_w_done;

  rstate_t       r_rstate;
  logic [31:0]   r_araddr;
  logic [2:0]    r_arprot;
  logic [SW-1:0] r_rsel;
  logic          r_rerr;

  logic [N-1:0]  w_m_awready;
  logic [N-1:0]  w_m_wready;
  logic [N-1:0]  w_m_bvalid;
  logic [N-1:0]  w_m_arready;
  logic [N-1:0]  w_m_rvalid;
  logic [1:0]    w_m_bresp [N];
  logic [1:0]    w_m_rresp [N];
  logic [31:0]   w_m_rdata [N];

  logic [SW:0]   w_awdec;
  logic [SW:0]   w_ardec;
  logic          w_wfwd;
  logic          w_wresp;
  logic          w_rfwd;
  logic          w_rresp;
  logic          w_aw_hs;
  logic          w_w_hs;

  // Returns {hit, index}; scanning downward lets the lowest index win.
  function automatic logic [SW:0] f_decode(input logic [19:0] page);
    logic [SW:0] res;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (page == BASE[i][31:12]) begin
        res = {1'b1, SW'(i)};
      end
    end
    return res;
  endfunction

  assign w_awdec = f_decode(s.awaddr[31:12]);
  assign w_ardec = f_decode(s.araddr[31:12]);

  assign w_wfwd  = (r_wstate == W_FWD);
  assign w_wresp = (r_wstate == W_RESP);
  assign w_rfwd  = (r_rstate == R_FWD);
  assign w_rresp = (r_rstate == R_RESP);

  assign w_aw_hs = w_wfwd && !r_aw_done && w_m_awready[r_wsel];
  assign w_w_hs  = w_wfwd && !r_w_done && s.wvalid && w_m_wready[r_wsel];

  // Upstream write side
  assign s.awready = (r_wstate == W_IDLE);
  assign s.wready  = (w_wfwd && w_m_wready[r_wsel] && !r_w_done) || (r_wstate == W_ERR);
  assign s.bvalid  = w_wresp && (r_werr || w_m_bvalid[r_wsel]);
  assign s.bresp   = r_werr ? c_RESP_DEC : w_m_bresp[r_wsel];

  // Upstream read side
  assign s.arready = (r_rstate == R_IDLE);
  assign s.rvalid  = w_rresp && (r_rerr || w_m_rvalid[r_rsel]);
  assign s.rresp   = r_rerr ? c_RESP_DEC : w_m_rresp[r_rsel];
  assign s.rdata   = r_rerr ? 32'h0 : w_m_rdata[r_rsel];

  for (genvar i = 0; i < N; i++) begin : g_port
    localparam logic [SW-1:0] c_idx = SW'(i);

    logic w_wsel;
    logic w_rsel;

    assign w_wsel = (r_wsel == c_idx);
    assign w_rsel = (r_rsel == c_idx);

    assign m[i].awaddr  = r_awaddr;
    assign m[i].awprot  = r_awprot;
    assign m[i].awvalid = w_wfwd && w_wsel && !r_aw_done;
    assign m[i].wdata   = s.wdata;
    assign m[i].wstrb   = s.wstrb;
    assign m[i].wvalid  = w_wfwd && w_wsel && s.wvalid && !r_w_done;
    assign m[i].bready  = w_wresp && !r_werr && w_wsel && s.bready;

    assign m[i].araddr  = r_araddr;
    assign m[i].arprot  = r_arprot;
    assign m[i].arvalid = w_rfwd && w_rsel;
    assign m[i].rready  = w_rresp && !r_rerr && w_rsel && s.rready;

    assign w_m_awready[i] = m[i].awready;
    assign w_m_wready[i]  = m[i].wready;
    assign w_m_bvalid[i]  = m[i].bvalid;
    assign w_m_bresp[i]   = m[i].bresp;
    assign w_m_arready[i] = m[i].arready;
    assign w_m_rvalid[i]  = m[i].rvalid;
    assign w_m_rresp[i]   = m[i].rresp;
    assign w_m_rdata[i]   = m[i].rdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_awprot  <= '0;
      r_wsel    <= '0;
      r_werr    <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (s.awvalid) begin
            r_awaddr  <= s.awaddr;
            r_awprot  <= s.awprot;
            r_wsel    <= w_awdec[SW-1:0];
            r_werr    <= !w_awdec[SW];
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wstate  <= w_awdec[SW] ? W_FWD : W_ERR;
          end
        end
        W_FWD: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          // Same-cycle AW and W completions both count toward leaving.
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_wstate <= W_RESP;
          end
        end
        W_ERR: begin
          if (s.wvalid) r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (s.bvalid && s.bready) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate <= R_IDLE;
      r_araddr <= '0;
      r_arprot <= '0;
      r_rsel   <= '0;
      r_rerr   <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (s.arvalid) begin
            r_araddr <= s.araddr;
            r_arprot <= s.arprot;
            r_rsel   <= w_ardec[SW-1:0];
            r_rerr   <= !w_ardec[SW];
            r_rstate <= w_ardec[SW] ? R_FWD : R_RESP;
          end
        end
        R_FWD: begin
          if (w_m_arready[r_rsel]) r_rstate <= R_RESP;
        end
        R_RESP: begin
          if (s.rvalid && s.rready) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4l_decoder.sv
// ============================================================================
// Module   : tb_axi4l_decoder
// Brief    : Scoreboard bench for axi4l_decoder with four slave models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi4l_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4l_if bus_s (.aclk(clk), .aresetn(rst_n));
  axi4l_if bus_m [4] (.aclk(clk), .aresetn(rst_n));

  axi4l_decoder #(.N(4)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .s       (bus_s),
    .m       (bus_m)
  );

  logic        aw_rdy  [4];
  int          rd_wait [4];
  logic [31:0] rd_data [4];
  logic [3:0]  m_ctl;
  logic [3:0]  m_valid;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // Slave models: configurable AW ready, registered B, R after rd_wait cycles.
  for (genvar i = 0; i < 4; i++) begin : g_slv
    logic [31:0] last_awaddr = '0;
    logic [31:0] last_wdata  = '0;
    logic [31:0] last_araddr = '0;
    int          wbeats = 0;
    int          vcnt   = 0;
    logic        got_aw, got_w, pend;
    int          cnt;
    logic        aw_hs, w_hs, ar_hs;

    assign bus_m[i].awready = aw_rdy[i];
    assign bus_m[i].wready  = 1'b1;
    assign bus_m[i].arready = 1'b1;
    assign aw_hs = bus_m[i].awvalid & bus_m[i].awready;
    assign w_hs  = bus_m[i].wvalid & bus_m[i].wready;
    assign ar_hs = bus_m[i].arvalid & bus_m[i].arready;
    assign m_valid[i] = bus_m[i].awvalid | bus_m[i].wvalid | bus_m[i].arvalid;
    assign m_ctl[i]   = m_valid[i] | bus_m[i].bready | bus_m[i].rready;

    always @(posedge clk) begin
      if (m_valid[i]) vcnt <= vcnt + 1;
      if (w_hs) begin
        wbeats     <= wbeats + 1;
        last_wdata <= bus_m[i].wdata;
      end
      if (aw_hs) last_awaddr <= bus_m[i].awaddr;
      if (ar_hs) last_araddr <= bus_m[i].araddr;
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        got_aw <= 1'b0; got_w <= 1'b0; pend <= 1'b0; cnt <= 0;
        bus_m[i].bvalid <= 1'b0; bus_m[i].bresp <= 2'b00;
        bus_m[i].rvalid <= 1'b0; bus_m[i].rresp <= 2'b00; bus_m[i].rdata <= '0;
      end else begin
        if ((aw_hs || got_aw) && (w_hs || got_w) && !bus_m[i].bvalid) begin
          bus_m[i].bvalid <= 1'b1;
          bus_m[i].bresp  <= 2'b00;
          got_aw <= 1'b0;
          got_w  <= 1'b0;
        end else begin
          if (aw_hs) got_aw <= 1'b1;
          if (w_hs)  got_w  <= 1'b1;
        end
        if (bus_m[i].bvalid && bus_m[i].bready) bus_m[i].bvalid <= 1'b0;

        if (ar_hs) begin
          if (rd_wait[i] == 0) begin
            bus_m[i].rvalid <= 1'b1;
            bus_m[i].rdata  <= rd_data[i];
            bus_m[i].rresp  <= 2'b00;
          end else begin
            pend <= 1'b1;
            cnt  <= rd_wait[i] - 1;
          end
        end else if (pend) begin
          if (cnt == 0) begin
            pend <= 1'b0;
            bus_m[i].rvalid <= 1'b1;
            bus_m[i].rdata  <= rd_data[i];
            bus_m[i].rresp  <= 2'b00;
          end else begin
            cnt <= cnt - 1;
          end
        end
        if (bus_m[i].rvalid && bus_m[i].rready) bus_m[i].rvalid <= 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every upstream B/R handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_s.bvalid && bus_s.bready) begin
        if (exp_b.size() == 0) timeout("b_unexpected");
        else check("bresp", {30'd0, bus_s.bresp}, {30'd0, exp_b.pop_front()});
      end
      if (bus_s.rvalid && bus_s.rready) begin
        if (exp_r.size() == 0) timeout("r_unexpected");
        else begin
          logic [33:0] e;
          e = exp_r.pop_front();
          check("rresp", {30'd0, bus_s.rresp}, {30'd0, e[33:32]});
          check("rdata", bus_s.rdata, e[31:0]);
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] exp, input int lead, input int stall,
                          output int t_aw, output int t_b);
    int k;
    t_aw = 0; t_b = 0;
    exp_b.push_back(exp);
    bus_s.awaddr = addr; bus_s.awprot = 3'b000;
    bus_s.wdata  = data; bus_s.wstrb  = 4'hF; bus_s.wvalid = 1'b1;
    for (int c = 0; c < lead; c++) begin
      @(negedge clk);
      check("w_early_wready", {31'd0, bus_s.wready}, 32'd0);
      @(posedge clk); #1;
    end
    bus_s.awvalid = 1'b1;
    k = 0; @(negedge clk);
    while (!bus_s.awready && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) timeout("aw_accept");
    t_aw = cyc;
    @(posedge clk); #1 bus_s.awvalid = 1'b0;
    k = 0; @(negedge clk);
    while (!bus_s.wready && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) timeout("w_accept");
    @(posedge clk); #1 bus_s.wvalid = 1'b0;
    k = 0;
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      if (bus_s.bvalid && bus_s.bresp == exp) k++;
      @(posedge clk); #1;
    end
    if (stall > 0) check("b_stall_stable", 32'(k), 32'(stall));
    bus_s.bready = 1'b1;
    k = 0; @(negedge clk);
    while (!bus_s.bvalid && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) timeout("b_wait");
    t_b = cyc;
    @(posedge clk); #1 bus_s.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] exp, output int t_ar, output int t_r,
                         output int ar_bad);
    int k;
    t_ar = 0; t_r = 0; ar_bad = 0;
    exp_r.push_back({exp, data});
    bus_s.araddr = addr; bus_s.arprot = 3'b000; bus_s.arvalid = 1'b1;
    k = 0; @(negedge clk);
    while (!bus_s.arready && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) timeout("ar_accept");
    t_ar = cyc;
    @(posedge clk); #1 bus_s.arvalid = 1'b0; bus_s.rready = 1'b1;
    k = 0; @(negedge clk);
    while (!bus_s.rvalid && k < 200) begin
      if (bus_s.arready) ar_bad++;
      @(negedge clk); k++;
    end
    if (k >= 200) timeout("r_wait");
    if (bus_s.arready) ar_bad++;
    t_r = cyc;
    @(posedge clk); #1 bus_s.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, tr_a, tr_r, bad, v0, ws, tca, tcb, tcra, tcrr, bad2;
    bus_s.awaddr = '0; bus_s.awprot = '0; bus_s.awvalid = 1'b0;
    bus_s.wdata  = '0; bus_s.wstrb  = '0; bus_s.wvalid  = 1'b0; bus_s.bready = 1'b0;
    bus_s.araddr = '0; bus_s.arprot = '0; bus_s.arvalid = 1'b0; bus_s.rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      aw_rdy[i] = 1'b1; rd_wait[i] = 0; rd_data[i] = 32'h1000_0000 + i;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'd0, bus_s.awready}, 32'd1);
    check("rst_arready", {31'd0, bus_s.arready}, 32'd1);
    check("rst_bvalid",  {31'd0, bus_s.bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, bus_s.rvalid},  32'd0);
    check("rst_m_ctl",   {28'd0, m_ctl},         32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Basic write to slave 0
    v0 = g_slv[1].vcnt + g_slv[2].vcnt + g_slv[3].vcnt;
    do_write(32'h4000_0000, 32'h0000_000A, 2'b00, 0, 0, ta, tb);
    check("wr_latency", 32'(tb - ta), 32'd2);
    check("m0_awaddr", g_slv[0].last_awaddr, 32'h4000_0000);
    check("m0_wdata",  g_slv[0].last_wdata,  32'h0000_000A);
    check("others_idle", 32'(g_slv[1].vcnt + g_slv[2].vcnt + g_slv[3].vcnt - v0), 32'd0);
    @(negedge clk);
    check("w_idle_after", {31'd0, bus_s.awready}, 32'd1);
    @(posedge clk); #1;

    // Slow read from slave 1
    rd_wait[1] = 3; rd_data[1] = 32'hDEAD_BEEF;
    do_read(32'h4000_1004, 32'hDEAD_BEEF, 2'b00, tr_a, tr_r, bad);
    check("arready_low", 32'(bad), 32'd0);
    check("m1_araddr", g_slv[1].last_araddr, 32'h4000_1004);
    check("slow_rd_latency", 32'(tr_r - tr_a), 32'd5);

    // Unmapped write and read
    v0 = g_slv[0].vcnt + g_slv[1].vcnt + g_slv[2].vcnt + g_slv[3].vcnt;
    do_write(32'h5000_0000, 32'h1234_5678, 2'b11, 0, 0, ta, tb);
    do_read(32'h5000_0000, 32'h0, 2'b11, tr_a, tr_r, bad);
    check("decerr_no_valid",
          32'(g_slv[0].vcnt + g_slv[1].vcnt + g_slv[2].vcnt + g_slv[3].vcnt - v0), 32'd0);

    // Early W, stalled B on slave 2
    ws = g_slv[2].wbeats;
    do_write(32'h4000_2008, 32'h0000_55AA, 2'b00, 2, 4, ta, tb);
    check("m2_one_beat", 32'(g_slv[2].wbeats - ws), 32'd1);
    check("m2_wdata", g_slv[2].last_wdata, 32'h0000_55AA);
    @(negedge clk);
    check("w_idle_after_stall", {31'd0, bus_s.awready}, 32'd1);
    @(posedge clk); #1;

    // Concurrent write to slave 0, read from slave 3
    rd_data[3] = 32'hCAFE_0003;
    fork
      do_write(32'h4000_0010, 32'h0000_1111, 2'b00, 0, 0, tca, tcb);
      do_read(32'h4000_3000, 32'hCAFE_0003, 2'b00, tcra, tcrr, bad2);
    join
    check("cc_wr_latency", 32'(tcb - tca), 32'd2);
    check("cc_rd_latency", 32'(tcrr - tcra), 32'd2);
    check("cc_m0_awaddr", g_slv[0].last_awaddr, 32'h4000_0010);
    check("cc_m3_araddr", g_slv[3].last_araddr, 32'h4000_3000);

    // Asynchronous reset during W_FWD
    aw_rdy[1] = 1'b0;
    bus_s.awaddr = 32'h4000_1000; bus_s.awprot = 3'b000; bus_s.awvalid = 1'b1;
    @(posedge clk); #1 bus_s.awvalid = 1'b0;
    @(posedge clk); #1;
    check("fwd_m1_awvalid", {31'd0, bus_m[1].awvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_m_ctl",   {28'd0, m_ctl},         32'd0);
    check("async_awready", {31'd0, bus_s.awready}, 32'd1);
    check("async_bvalid",  {31'd0, bus_s.bvalid},  32'd0);
    @(posedge clk); #1 rst_n = 1'b1; aw_rdy[1] = 1'b1;
    @(posedge clk); #1;
    do_write(32'h4000_1000, 32'h0000_0077, 2'b00, 0, 0, ta, tb);
    check("post_rst_wdata", g_slv[1].last_wdata, 32'h0000_0077);
    check("post_rst_latency", 32'(tb - ta), 32'd2);

    repeat (5) @(posedge clk);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);
    check("r_queue_empty", 32'(exp_r.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
